// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order queue of fetched branch predictions, checked
// against EX resolution. Emits predictor update pulses, mispredict redirect
// and a multi-cycle flush, plus sticky error flags and saturating stats.
module branch_resolve_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push_valid,
    input  logic [PC_WIDTH-1:0] push_pc,
    input  logic                push_pred_taken,
    input  logic [PC_WIDTH-1:0] push_pred_target,
    output logic                queue_full,
    input  logic                resolve_valid,
    input  logic                resolve_taken,
    input  logic [PC_WIDTH-1:0] resolve_target,
    output logic                update_en,
    output logic                actual_taken,
    output logic [PC_WIDTH-1:0] update_pc,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush,
    output logic                err_underflow,
    output logic                err_overflow,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t              state;
    logic [FW-1:0]       flush_cnt;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;

    logic [PC_WIDTH-1:0] pc_q  [DEPTH];
    logic [PC_WIDTH-1:0] tgt_q [DEPTH];
    logic [DEPTH-1:0]    pt_q;

    logic                pop_ok, push_ok, mis;
    logic [PC_WIDTH-1:0] head_pc, head_tgt;
    logic                head_pt;

    assign queue_full = (count == CW'(DEPTH));
    assign head_pc    = pc_q[rd_ptr];
    assign head_tgt   = tgt_q[rd_ptr];
    assign head_pt    = pt_q[rd_ptr];

    // Accept/pop decisions; a pop frees a slot so push-while-full is legal alongside it
    always_comb begin
        pop_ok  = (state == RUN) && resolve_valid && (count != '0);
        push_ok = (state == RUN) && push_valid && (!queue_full || pop_ok);
        mis     = pop_ok && ((head_pt != resolve_taken) ||
                             (resolve_taken && (head_tgt != resolve_target)));
    end

    // Prediction storage: data only, validity is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_q[wr_ptr]  <= push_pc;
            tgt_q[wr_ptr] <= push_pred_target;
            pt_q[wr_ptr]  <= push_pred_taken;
        end
    end

    // Control FSM, queue pointers, registered outputs, flags and statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RUN;
            flush_cnt        <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            update_en        <= 1'b0;
            actual_taken     <= 1'b0;
            update_pc        <= '0;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            flush            <= 1'b0;
            err_underflow    <= 1'b0;
            err_overflow     <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            update_en  <= 1'b0;
            mispredict <= 1'b0;

            if (pop_ok) begin
                update_en    <= 1'b1;
                actual_taken <= resolve_taken;
                update_pc    <= head_pc;
                if (branch_count != 32'hFFFF_FFFF)
                    branch_count <= branch_count + 32'd1;
            end

            if ((state == RUN) && resolve_valid && (count == '0))
                err_underflow <= 1'b1;
            if ((state == RUN) && push_valid && queue_full && !pop_ok)
                err_overflow <= 1'b1;

            case (state)
                RUN: begin
                    if (mis) begin
                        mispredict  <= 1'b1;
                        redirect_pc <= resolve_taken ? resolve_target
                                                     : head_pc + PC_WIDTH'(4);
                        if (mispredict_count != 32'hFFFF_FFFF)
                            mispredict_count <= mispredict_count + 32'd1;
                        flush     <= 1'b1;
                        flush_cnt <= FW'(FLUSH_CYCLES - 1);
                        state     <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: state <= RUN;
            endcase

            // A mispredict squashes every queued entry and any same-cycle push
            if (mis) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: the driver runs a queue-level model each cycle and pushes
// expected update/mispredict responses; a monitor pops on update_en.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 0, reset_n = 0;
    logic        push_valid = 0, push_pred_taken = 0;
    logic [31:0] push_pc = 0, push_pred_target = 0;
    logic        resolve_valid = 0, resolve_taken = 0;
    logic [31:0] resolve_target = 0;
    logic        queue_full, update_en, actual_taken, mispredict, flush;
    logic        err_underflow, err_overflow;
    logic [31:0] update_pc, redirect_pc, branch_count, mispredict_count;

    branch_resolve_unit #(.PC_WIDTH(32), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
        .push_pred_target(push_pred_target), .queue_full(queue_full),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .update_en(update_en),
        .actual_taken(actual_taken), .update_pc(update_pc), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .flush(flush), .err_underflow(err_underflow),
        .err_overflow(err_overflow), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic pt; logic [31:0] tgt; } ent_t;
    typedef struct { logic [31:0] pc; logic taken; logic mis; logic [31:0] redir; } exp_t;

    ent_t mq[$];
    exp_t eq[$];
    int   rec;
    bit   m_uf, m_of;
    logic [31:0] m_bc, m_mc;

    // snapshot of model state visible during the current cycle
    bit   s_flush, s_full, s_uf, s_of, mon_en;
    logic [31:0] s_bc, s_mc;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        mq.delete(); eq.delete();
        rec = 0; m_uf = 0; m_of = 0; m_bc = 0; m_mc = 0;
        s_flush = 0; s_full = 0; s_uf = 0; s_of = 0; s_bc = 0; s_mc = 0;
    endtask

    // One cycle of the architectural rules applied to this cycle's inputs
    task automatic mstep(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptgt, input logic rv, input logic rt,
                         input logic [31:0] rtgt);
        bit mis;
        ent_t e;
        exp_t x;
        mis = 0;
        if (rec > 0) begin
            rec--;
            return;
        end
        if (rv) begin
            if (mq.size() == 0) m_uf = 1;
            else begin
                e = mq.pop_front();
                mis = (e.pt != rt) || (rt && e.tgt != rtgt);
                x.pc = e.pc; x.taken = rt; x.mis = mis;
                x.redir = rt ? rtgt : e.pc + 32'd4;
                eq.push_back(x);
                if (m_bc != 32'hFFFF_FFFF) m_bc++;
                if (mis) begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc++;
                    mq.delete();
                    rec = FLUSH_CYCLES;
                end
            end
        end
        if (!mis && pv) begin
            if (mq.size() < DEPTH) begin
                e.pc = ppc; e.pt = pt; e.tgt = ptgt;
                mq.push_back(e);
            end else m_of = 1;
        end
    endtask

    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt);
        @(posedge clk); #1;
        s_flush = (rec > 0); s_full = (mq.size() == DEPTH);
        s_uf = m_uf; s_of = m_of; s_bc = m_bc; s_mc = m_mc;
        push_valid = pv; push_pc = ppc; push_pred_taken = pt; push_pred_target = ptgt;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
        mstep(pv, ppc, pt, ptgt, rv, rt, rtgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares registered responses and status against the scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n) begin
                chk("flush", flush, s_flush);
                chk("queue_full", queue_full, s_full);
                chk("err_underflow", err_underflow, s_uf);
                chk("err_overflow", err_overflow, s_of);
                chk("branch_count", branch_count, s_bc);
                chk("mispredict_count", mispredict_count, s_mc);
                if (update_en) begin
                    if (eq.size() == 0) chk("unexpected_update_en", 1, 0);
                    else begin
                        x = eq.pop_front();
                        chk("update_pc", update_pc, x.pc);
                        chk("actual_taken", actual_taken, x.taken);
                        chk("mispredict", mispredict, x.mis);
                        if (x.mis) chk("redirect_pc", redirect_pc, x.redir);
                    end
                end else if (mispredict) chk("mispredict_without_update", 1, 0);
            end
        end
    end

    initial begin
        logic pv, pt, rv, rt;
        logic [31:0] ppc, ptgt, rtgt;
        mon_en = 0;
        mreset();
        #12;
        chk("reset_update_en", update_en, 0);
        chk("reset_flush", flush, 0);
        chk("reset_queue_full", queue_full, 0);
        chk("reset_mispredict", mispredict, 0);
        @(posedge clk); #2; reset_n = 1; mon_en = 1;

        // correct not-taken prediction
        cyc(1, 32'h100, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // taken with wrong target -> redirect to actual target
        cyc(1, 32'h100, 1, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h240);
        idle(4);

        // three in flight, first predicted T resolved NT; later resolves ignored
        cyc(1, 32'h100, 1, 32'h200, 0, 0, 0);
        cyc(1, 32'h110, 0, 32'h0, 0, 0, 0);
        cyc(1, 32'h120, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h130, 0, 32'h0, 1, 0, 0);
        idle(2);

        // fill, push+resolve while full (legal), then push while full -> overflow
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h400 + 32'(i * 4), 0, 0, 0, 0, 0);
        cyc(1, 32'h500, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 32'h600, 0, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // resolve with an empty queue -> underflow, no update
        cyc(0, 0, 0, 0, 1, 1, 32'h700);
        idle(2);

        // pc wrap on not-taken redirect
        cyc(1, 32'hFFFF_FFFC, 1, 32'h800, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(4);

        // reset asserted during RECOVER
        cyc(1, 32'h300, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h380);
        idle(1);
        @(negedge clk); #2;
        mon_en = 0; reset_n = 0; #1;
        chk("rst_recover_flush", flush, 0);
        chk("rst_recover_queue_full", queue_full, 0);
        chk("rst_recover_branch_count", branch_count, 0);
        chk("rst_recover_mispredict_count", mispredict_count, 0);
        chk("rst_recover_err_overflow", err_overflow, 0);
        chk("leftover_expected_before_reset", eq.size(), 0);
        mreset();
        @(posedge clk); #2; reset_n = 1; mon_en = 1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pv = ($urandom_range(0, 9) < 6);
            ppc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            pt = $urandom_range(0, 1);
            ptgt = $urandom_range(0, 1) ? 32'h200 : 32'h240;
            rv = ($urandom_range(0, 9) < 4);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt = mq[0].pt; rtgt = mq[0].tgt;
                if ($urandom_range(0, 3) == 0) rtgt = rtgt ^ 32'h40;
            end else begin
                rt = $urandom_range(0, 1);
                rtgt = $urandom_range(0, 1) ? 32'h200 : 32'h240;
            end
            cyc(pv, ppc, pt, ptgt, rv, rt, rtgt);
        end
        idle(5);
        @(negedge clk); #2;
        chk("leftover_expected", eq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
